// File: rtl/wb_write_scheduler.sv
// Writeback scheduler: two ALU lanes plus a buffered load stream
// share the register file's two write ports.
module wb_write_scheduler #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu1_valid,
  input  logic [ADDR_W-1:0]        alu1_dest,
  input  logic [DATA_W-1:0]        alu1_data,
  input  logic                     alu2_valid,
  input  logic [ADDR_W-1:0]        alu2_dest,
  input  logic [DATA_W-1:0]        alu2_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic [1:0]               wr_enable,
  output logic [ADDR_W-1:0]        wr_dest1,
  output logic [ADDR_W-1:0]        wr_dest2,
  output logic [DATA_W-1:0]        wr_data1,
  output logic [DATA_W-1:0]        wr_data2,
  output logic                     starve_active,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] q_dest [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_kill;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [SW-1:0]     starve_cnt;
  logic [SW:0]       cnt_inc;

  logic              acc1, acc2;
  logic              kill1, kill2;
  logic              push, pop1, pop2;
  logic              busy;
  logic [1:0]        n_pop;
  logic [PW-1:0]     h0, h1, hp2;
  logic [DEPTH-1:0]  hit_q;
  logic              hit_mem;
  logic [1:0]        n_en;
  logic [ADDR_W-1:0] n_dest1, n_dest2;
  logic [DATA_W-1:0] n_data1, n_data2;

  assign alu_ready = !starve_active;
  assign mem_ready = fifo_count < CW'(DEPTH);

  assign acc1  = alu1_valid && alu_ready;
  assign acc2  = alu2_valid && alu_ready;
  assign kill1 = acc1 && (alu1_dest != '0);
  assign kill2 = acc2 && (alu2_dest != '0);
  assign push  = mem_valid && mem_ready && (mem_dest != '0);
  assign busy  = fifo_count != '0;

  // Pops only see entries present at cycle start: no bypass.
  assign pop1  = !acc1 && busy;
  assign pop2  = !acc2 && (acc1 ? busy : (fifo_count >= CW'(2)));
  assign n_pop = {1'b0, pop1} + {1'b0, pop2};
  assign h0    = rd_ptr;
  assign h1    = rd_ptr + PW'(1);
  assign hp2   = pop1 ? h1 : h0;
  assign cnt_inc = {1'b0, starve_cnt} + 1'b1;

  // A younger ALU write cancels any older buffered load to the same reg,
  // including one leaving the FIFO this very cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit_q[i] = (kill1 && q_dest[i] == alu1_dest) ||
                 (kill2 && q_dest[i] == alu2_dest);
    end
    hit_mem = (kill1 && mem_dest == alu1_dest) ||
              (kill2 && mem_dest == alu2_dest);
  end

  always_comb begin
    n_en    = '0;
    n_dest1 = '0;
    n_data1 = '0;
    n_dest2 = '0;
    n_data2 = '0;
    if (acc1) begin
      n_en[0] = (alu1_dest != '0) &&
                !(acc2 && alu1_dest == alu2_dest);
      n_dest1 = alu1_dest;
      n_data1 = alu1_data;
    end else if (pop1) begin
      n_en[0] = !q_kill[h0] && !hit_q[h0];
      n_dest1 = q_dest[h0];
      n_data1 = q_data[h0];
    end
    if (acc2) begin
      n_en[1] = alu2_dest != '0;
      n_dest2 = alu2_dest;
      n_data2 = alu2_data;
    end else if (pop2) begin
      n_en[1] = !q_kill[hp2] && !hit_q[hp2];
      n_dest2 = q_dest[hp2];
      n_data2 = q_data[hp2];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_dest[i] <= '0;
        q_data[i] <= '0;
      end
      q_kill        <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      starve_cnt    <= '0;
      starve_active <= 1'b0;
      wr_enable     <= '0;
      wr_dest1      <= '0;
      wr_dest2      <= '0;
      wr_data1      <= '0;
      wr_data2      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit_q[i]) q_kill[i] <= 1'b1;
      end
      if (push) begin
        q_dest[wr_ptr] <= mem_dest;
        q_data[wr_ptr] <= mem_data;
        q_kill[wr_ptr] <= hit_mem;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      rd_ptr     <= rd_ptr + PW'(n_pop);
      fifo_count <= fifo_count + CW'(push) - CW'(n_pop);
      if (!busy || n_pop != '0) begin
        starve_cnt    <= '0;
        starve_active <= 1'b0;
      end else begin
        if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= cnt_inc[SW-1:0];
        starve_active <= cnt_inc >= (SW+1)'(STARVE_LIMIT);
      end
      wr_enable <= n_en;
      wr_dest1  <= n_dest1;
      wr_dest2  <= n_dest2;
      wr_data1  <= n_data1;
      wr_data2  <= n_data2;
    end
  end

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: directed steps then random traffic,
// each cycle checked against a queue-based reference model.
module tb_wb_write_scheduler;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu1_valid = 1'b0, alu2_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu1_dest = '0, alu2_dest = '0, mem_dest = '0;
  logic [31:0] alu1_data = '0, alu2_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, starve_active;
  logic [1:0]  wr_enable;
  logic [4:0]  wr_dest1, wr_dest2;
  logic [31:0] wr_data1, wr_data2;
  logic [2:0]  fifo_count;

  wb_write_scheduler #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .alu1_valid(alu1_valid), .alu1_dest(alu1_dest), .alu1_data(alu1_data),
    .alu2_valid(alu2_valid), .alu2_dest(alu2_dest), .alu2_data(alu2_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .wr_enable(wr_enable),
    .wr_dest1(wr_dest1), .wr_dest2(wr_dest2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .starve_active(starve_active), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    bit          killed;
  } ent_t;

  ent_t        q[$];
  int          waitc;
  bit          m_starve;
  logic [1:0]  m_en;
  logic [4:0]  m_d1, m_d2;
  logic [31:0] m_x1, m_x2;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit later_write(input bit a1, input logic [4:0] d1,
                                     input bit a2, input logic [4:0] d2,
                                     input logic [4:0] d);
    return (a1 && d1 != 0 && d == d1) || (a2 && d2 != 0 && d == d2);
  endfunction

  task automatic compare_all();
    chk("alu_ready", alu_ready, !m_starve);
    chk("mem_ready", mem_ready, q.size() < DEPTH);
    chk("fifo_count", fifo_count, q.size());
    chk("starve", starve_active, m_starve);
    chk("wr_enable", wr_enable, m_en);
    if (m_en[0]) begin
      chk("wr_dest1", wr_dest1, m_d1);
      chk("wr_data1", wr_data1, m_x1);
    end
    if (m_en[1]) begin
      chk("wr_dest2", wr_dest2, m_d2);
      chk("wr_data2", wr_data2, m_x2);
    end
  endtask

  task automatic step(input bit v1, input logic [4:0] d1, input logic [31:0] x1,
                      input bit v2, input logic [4:0] d2, input logic [31:0] x2,
                      input bit mv, input logic [4:0] md, input logic [31:0] mx);
    bit   a1, a2, mr;
    int   slots, np, pre;
    ent_t p[$];
    ent_t e;
    alu1_valid = v1; alu1_dest = d1; alu1_data = x1;
    alu2_valid = v2; alu2_dest = d2; alu2_data = x2;
    mem_valid  = mv; mem_dest  = md; mem_data  = mx;
    a1 = v1 && !m_starve;
    a2 = v2 && !m_starve;
    pre = q.size();
    mr = pre < DEPTH;
    slots = (a1 ? 0 : 1) + (a2 ? 0 : 1);
    np = (slots < pre) ? slots : pre;
    for (int i = 0; i < np; i++) p.push_back(q.pop_front());
    m_en = 2'b00;
    if (a1) begin
      m_en[0] = d1 != 0 && !(a2 && d1 == d2);
      m_d1 = d1; m_x1 = x1;
    end else if (p.size() > 0) begin
      e = p.pop_front();
      m_en[0] = !e.killed && !later_write(a1, d1, a2, d2, e.dest);
      m_d1 = e.dest; m_x1 = e.data;
    end
    if (a2) begin
      m_en[1] = d2 != 0;
      m_d2 = d2; m_x2 = x2;
    end else if (p.size() > 0) begin
      e = p.pop_front();
      m_en[1] = !e.killed && !later_write(a1, d1, a2, d2, e.dest);
      m_d2 = e.dest; m_x2 = e.data;
    end
    foreach (q[i]) if (later_write(a1, d1, a2, d2, q[i].dest)) q[i].killed = 1;
    if (mv && mr && md != 0) begin
      e.dest = md; e.data = mx;
      e.killed = later_write(a1, d1, a2, d2, md);
      q.push_back(e);
    end
    if (pre == 0 || np > 0) begin
      waitc = 0;
      m_starve = 0;
    end else begin
      waitc++;
      m_starve = waitc >= LIMIT;
    end
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    alu1_valid = 0; alu2_valid = 0; mem_valid = 0;
    q.delete();
    waitc = 0; m_starve = 0; m_en = 0;
    @(posedge clock);
    #1;
    chk("rst_en", wr_enable, 2'b00);
    chk("rst_dest1", wr_dest1, 0);
    chk("rst_dest2", wr_dest2, 0);
    chk("rst_data1", wr_data1, 0);
    chk("rst_data2", wr_data2, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_starve", starve_active, 0);
    reset = 1'b1;
  endtask

  initial begin
    int lows;
    waitc = 0; m_starve = 0; m_en = 0;
    #1;
    do_reset();
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);

    // ALU-only traffic
    step(1, 3, 32'hAAAA0001, 1, 4, 32'hBBBB0002, 0, 0, 0);
    chk("alu_en", wr_enable, 2'b11);
    chk("alu_d1", wr_dest1, 3);
    chk("alu_x1", wr_data1, 32'hAAAA0001);
    chk("alu_d2", wr_dest2, 4);
    chk("alu_x2", wr_data2, 32'hBBBB0002);
    chk("alu_cnt", fifo_count, 0);

    // Load into free slot
    step(0, 0, 0, 0, 0, 0, 1, 7, 32'h12345678);
    chk("ld_cnt", fifo_count, 1);
    step(1, 10, 32'h1, 0, 0, 0, 0, 0, 0);
    chk("ld_en", wr_enable, 2'b11);
    chk("ld_d2", wr_dest2, 7);
    chk("ld_x2", wr_data2, 32'h12345678);

    // Starvation with both lanes saturated
    lows = 0;
    step(1, 11, 32'h11, 1, 12, 32'h12, 1, 8, 32'h88);
    for (int i = 0; i < 7; i++) begin
      step(1, 11, 32'h11, 1, 12, 32'h12, 0, 0, 0);
      if (!alu_ready) lows++;
      if (i == 2) chk("starve_on", starve_active, 1);
      if (i == 3) begin
        chk("starve_en", wr_enable, 2'b01);
        chk("starve_d1", wr_dest1, 8);
        chk("starve_ready", alu_ready, 1);
      end
    end
    chk("starve_lows", lows, 1);

    // WAW kill: buffered, then same-cycle
    step(1, 13, 32'h13, 1, 14, 32'h14, 1, 5, 32'h55);
    step(0, 0, 0, 1, 5, 32'h5A5A, 0, 0, 0);
    chk("waw_en", wr_enable, 2'b10);
    chk("waw_x2", wr_data2, 32'h5A5A);
    step(1, 5, 32'hA5, 1, 15, 32'h15, 1, 5, 32'h66);
    idle();
    chk("waw2_en", wr_enable, 2'b00);
    chk("waw2_cnt", fifo_count, 0);

    // Full, drain, wrap
    for (int i = 0; i < 4; i++)
      step(1, 20, 32'h20, 1, 21, 32'h21, 1, 5'(16 + i), 32'h100 + i);
    chk("full_cnt", fifo_count, 4);
    chk("full_ready", mem_ready, 0);
    for (int i = 0; i < 4; i++) idle();
    chk("drained", fifo_count, 0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 0, 0, 1, 5'(22 + i), 32'h200 + i);
    idle();
    step(1, 9, 32'h91, 1, 9, 32'h92, 0, 0, 0);
    chk("same_en", wr_enable, 2'b10);
    chk("same_x2", wr_data2, 32'h92);

    // x0 and reset mid-operation
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
    chk("x0_cnt", fifo_count, 0);
    idle();
    chk("x0_en", wr_enable, 2'b00);
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h1, 1, 2, 32'h2, 1, 5'(24 + i), 32'h300 + i);
    chk("pre_rst_cnt", fifo_count, 3);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_en", wr_enable, 2'b00);
    end

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
           ($urandom % 3) != 0, 5'($urandom % 8), $urandom,
           ($urandom % 2) != 0, 5'($urandom % 8), $urandom);
    for (int i = 0; i < 8; i++) idle();
    chk("final_cnt", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
